btn_conditioner: RTL and testbench

Front-end input conditioner for the calculator. Takes the five raw push-buttons and the 16 slide switches straight from the board pins and feeds `calc`. It synchronizes every input to `clk`, debounces each button, and emits exactly one single-cycle press pulse per debounced press. Its outputs drive `calc`'s `btnc/btnl/btnu/btnr/btnd` and `sw` inputs, so each physical press causes exactly one accumulator update.

---
 rtl/calc_pkg.sv | 19 +
 rtl/btn_debounce.sv | 81 ++++++++
 rtl/btn_conditioner.sv | 63 ++++++
 tb/tb_btn_conditioner.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator front end.
package calc_pkg;

   typedef enum logic [1:0] {
      IDLE,
      PRESS_WAIT,
      HELD,
      RELEASE_WAIT
   } btn_state_t;

   localparam int N_BTN = 5;

   localparam int BTN_C = 0;
   localparam int BTN_L = 1;
   localparam int BTN_U = 2;
   localparam int BTN_R = 3;
   localparam int BTN_D = 4;

endpackage

// File: rtl/btn_debounce.sv
// One button channel: two-flop synchronizer, debounce FSM, and registered
// press pulse and held level.
module btn_debounce
   import calc_pkg::*;
#(
   parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic pulse,
   output logic level
);

   localparam logic [15:0] LAST = DEBOUNCE_CYCLES - 16'd1;

   logic       s1;
   logic       s2;
   btn_state_t state;
   logic [15:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1    <= 1'b0;
         s2    <= 1'b0;
         state <= IDLE;
         cnt   <= 16'd0;
         pulse <= 1'b0;
         level <= 1'b0;
      end else begin
         s1    <= raw;
         s2    <= s1;
         pulse <= 1'b0;
         case (state)
            IDLE: begin
               if (s2) begin
                  state <= PRESS_WAIT;
                  cnt   <= 16'd1;
               end
            end
            PRESS_WAIT: begin
               if (!s2) begin
                  state <= IDLE;
                  cnt   <= 16'd0;
               end else if (cnt == LAST) begin
                  state <= HELD;
                  cnt   <= 16'd0;
                  pulse <= 1'b1;
                  level <= 1'b1;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            HELD: begin
               // No auto-repeat: only a release can leave this state.
               if (!s2) begin
                  state <= RELEASE_WAIT;
                  cnt   <= 16'd1;
               end
            end
            RELEASE_WAIT: begin
               if (s2) begin
                  state <= HELD;
                  cnt   <= 16'd0;
               end else if (cnt == LAST) begin
                  state <= IDLE;
                  cnt   <= 16'd0;
                  level <= 1'b0;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= 16'd0;
            end
         endcase
      end
   end

endmodule

// File: rtl/btn_conditioner.sv
// Board-pin conditioner for calc: debounced one-shot button presses and
// synchronized switches.
module btn_conditioner
   import calc_pkg::*;
#(
   parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        btnc_raw,
   input  logic        btnl_raw,
   input  logic        btnu_raw,
   input  logic        btnr_raw,
   input  logic        btnd_raw,
   input  logic [15:0] sw_raw,
   output logic        btnc,
   output logic        btnl,
   output logic        btnu,
   output logic        btnr,
   output logic        btnd,
   output logic [4:0]  btn_level,
   output logic [15:0] sw
);

   logic [N_BTN-1:0] btn_raw;
   logic [N_BTN-1:0] btn_pulse;
   logic [15:0]      sw_s1;
   logic [15:0]      sw_s2;

   assign btn_raw = {btnd_raw, btnr_raw, btnu_raw, btnl_raw, btnc_raw};

   for (genvar i = 0; i < N_BTN; i++) begin : g_btn
      btn_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
         .clk  (clk),
         .rst  (rst),
         .raw  (btn_raw[i]),
         .pulse(btn_pulse[i]),
         .level(btn_level[i])
      );
   end

   assign btnc = btn_pulse[BTN_C];
   assign btnl = btn_pulse[BTN_L];
   assign btnu = btn_pulse[BTN_U];
   assign btnr = btn_pulse[BTN_R];
   assign btnd = btn_pulse[BTN_D];

   // Switches are level inputs to calc, so they are synchronized only.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sw_s1 <= 16'd0;
         sw_s2 <= 16'd0;
      end else begin
         sw_s1 <= sw_raw;
         sw_s2 <= sw_s1;
      end
   end

   assign sw = sw_s2;

endmodule

// File: tb/tb_btn_conditioner.sv
// Scoreboard bench for btn_conditioner with a run-length reference model.
module tb_btn_conditioner;

   localparam logic [15:0] DBC = 16'd4;
   localparam int          DI  = 4;

   logic        clk;
   logic        rst;
   logic        btnc_raw, btnl_raw, btnu_raw, btnr_raw, btnd_raw;
   logic [15:0] sw_raw;
   logic        btnc, btnl, btnu, btnr, btnd;
   logic [4:0]  btn_level;
   logic [15:0] sw;

   btn_conditioner #(
      .DEBOUNCE_CYCLES(DBC)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .btnc_raw (btnc_raw),
      .btnl_raw (btnl_raw),
      .btnu_raw (btnu_raw),
      .btnr_raw (btnr_raw),
      .btnd_raw (btnd_raw),
      .sw_raw   (sw_raw),
      .btnc     (btnc),
      .btnl     (btnl),
      .btnu     (btnu),
      .btnr     (btnr),
      .btnd     (btnd),
      .btn_level(btn_level),
      .sw       (sw)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [4:0]  p;
      logic [4:0]  l;
      logic [15:0] s;
   } exp_t;

   exp_t sb_q[$];

   int total = 0;
   int bad   = 0;

   // Reference model: level flips once the synchronized input has differed
   // from it for DI consecutive edges; a pulse marks each rising flip.
   logic [20:0] m_s1, m_s2;
   logic [4:0]  m_lvl, m_pulse;
   int          run[5];
   int          edge_no = 0;
   int          pulse_cnt[5];
   int          last_pulse_edge[5];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h (edge %0d)", tag, got, exp, edge_no);
      end
   endtask

   task automatic model_clear();
      m_s1    = '0;
      m_s2    = '0;
      m_lvl   = '0;
      m_pulse = '0;
      for (int i = 0; i < 5; i++) run[i] = 0;
   endtask

   task automatic model_edge();
      logic [20:0] raw_v;
      raw_v = {sw_raw, btnd_raw, btnr_raw, btnu_raw, btnl_raw, btnc_raw};
      if (rst) begin
         model_clear();
      end else begin
         for (int i = 0; i < 5; i++) begin
            m_pulse[i] = 1'b0;
            if (m_s2[i] != m_lvl[i]) run[i]++;
            else run[i] = 0;
            if (run[i] == DI) begin
               m_lvl[i]   = ~m_lvl[i];
               m_pulse[i] = m_lvl[i];
               run[i]     = 0;
            end
         end
         m_s2 = m_s1;
         m_s1 = raw_v;
      end
      sb_q.push_back('{p: m_pulse, l: m_lvl, s: m_s2[20:5]});
   endtask

   task automatic step();
      exp_t       e;
      logic [4:0] got_p;
      @(posedge clk);
      edge_no++;
      model_edge();
      @(negedge clk);
      if (sb_q.size() == 0) begin
         check_eq("sb_empty", 32'd1, 32'd0);
      end else begin
         e     = sb_q.pop_front();
         got_p = {btnd, btnr, btnu, btnl, btnc};
         check_eq("pulse", 32'(got_p), 32'(e.p));
         check_eq("level", 32'(btn_level), 32'(e.l));
         check_eq("sw", 32'(sw), 32'(e.s));
         for (int i = 0; i < 5; i++) begin
            if (got_p[i]) begin
               pulse_cnt[i]++;
               last_pulse_edge[i] = edge_no;
            end
         end
      end
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   int k, m, f, c_before;

   initial begin
      rst = 1'b1;
      {btnc_raw, btnl_raw, btnu_raw, btnr_raw, btnd_raw} = '0;
      sw_raw = 16'd0;
      model_clear();
      for (int i = 0; i < 5; i++) begin
         pulse_cnt[i]       = 0;
         last_pulse_edge[i] = -1;
      end
      #1;
      check_eq("rst_pulse", 32'({btnd, btnr, btnu, btnl, btnc}), 32'd0);
      check_eq("rst_level", 32'(btn_level), 32'd0);
      check_eq("rst_sw", 32'(sw), 32'd0);
      steps(3);
      rst = 1'b0;
      steps(3);

      // Clean press on C
      k = edge_no + 1;
      btnc_raw = 1'b1;
      steps(10);
      check_eq("clean_cnt", 32'(pulse_cnt[0]), 32'd1);
      check_eq("clean_edge", 32'(last_pulse_edge[0]), 32'(k + 1 + DI));
      check_eq("clean_lvl", 32'(btn_level[0]), 32'd1);
      btnc_raw = 1'b0;
      steps(10);

      // Bounce on L
      btnl_raw = 1'b1; step();
      btnl_raw = 1'b0; step();
      btnl_raw = 1'b1; step();
      btnl_raw = 1'b0; step();
      m = edge_no + 1;
      btnl_raw = 1'b1;
      steps(12);
      check_eq("bounce_cnt", 32'(pulse_cnt[1]), 32'd1);
      check_eq("bounce_edge", 32'(last_pulse_edge[1]), 32'(m + 1 + DI));

      // Release glitch on U
      btnu_raw = 1'b1;
      steps(10);
      btnu_raw = 1'b0;
      steps(2);
      btnu_raw = 1'b1;
      steps(12);
      check_eq("glitch_cnt", 32'(pulse_cnt[2]), 32'd1);
      check_eq("glitch_lvl", 32'(btn_level[2]), 32'd1);

      // Simultaneous R and D
      btnr_raw = 1'b1;
      btnd_raw = 1'b1;
      steps(10);
      check_eq("simul_r_cnt", 32'(pulse_cnt[3]), 32'd1);
      check_eq("simul_d_cnt", 32'(pulse_cnt[4]), 32'd1);
      check_eq("simul_edge", 32'(last_pulse_edge[3]), 32'(last_pulse_edge[4]));

      // Switches
      c_before = pulse_cnt[0] + pulse_cnt[1] + pulse_cnt[2] + pulse_cnt[3] + pulse_cnt[4];
      sw_raw = 16'h8001;
      step();
      check_eq("sw_lat1", 32'(sw), 32'd0);
      step();
      check_eq("sw_lat2", 32'(sw), 32'h8001);
      steps(4);
      check_eq("sw_nobtn", 32'(pulse_cnt[0] + pulse_cnt[1] + pulse_cnt[2] + pulse_cnt[3]
                                + pulse_cnt[4]), 32'(c_before));

      // Reset mid-PRESS_WAIT on C
      c_before = pulse_cnt[0];
      btnc_raw = 1'b1;
      steps(4);
      #2 rst = 1'b1;
      #1;
      model_clear();
      check_eq("arst_pulse", 32'({btnd, btnr, btnu, btnl, btnc}), 32'd0);
      check_eq("arst_level", 32'(btn_level), 32'd0);
      check_eq("arst_sw", 32'(sw), 32'd0);
      steps(3);
      check_eq("rst_nopulse", 32'(pulse_cnt[0]), 32'(c_before));
      rst = 1'b0;
      f = edge_no + 1;
      steps(10);
      check_eq("post_rst_cnt", 32'(pulse_cnt[0]), 32'(c_before + 1));
      check_eq("post_rst_edge", 32'(last_pulse_edge[0]), 32'(f + 1 + DI));

      // Release everything and let it settle
      {btnc_raw, btnl_raw, btnu_raw, btnr_raw, btnd_raw} = '0;
      sw_raw = 16'h0000;
      steps(12);
      check_eq("final_lvl", 32'(btn_level), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
